// File: rtl/rtl_bigreg_writer_pkg.sv
// ============================================================================
// Module : rtl_bigreg_writer_pkg
// Brief  : Mem-map layout constants, write-beat type and publisher FSM states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rtl_bigreg_writer_pkg;

   localparam int BUFF_TIMESTAMP_WIDTH    = 32;
   localparam int WD_DATA_WIDTH           = 16;
   localparam int MEM_SIZE                = 256;
   localparam int MEM_ID_WIDTH            = $clog2(MEM_SIZE);
   localparam int BUFF_TIME_BASE_ID       = 27;
   localparam int BUFF_TIME_VALID_ID      = 29;
   localparam int BUFF_SAMPLES            = BUFF_TIMESTAMP_WIDTH / WD_DATA_WIDTH;
   localparam int BUFF_TIME_PUBLISH_BEATS = BUFF_SAMPLES + 2;

   typedef struct packed {
      logic [MEM_ID_WIDTH-1:0]  id;
      logic [WD_DATA_WIDTH-1:0] data;
   } mem_wr_beat_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      INVAL    = 3'd1,
      WORDS    = 3'd2,
      SETV     = 3'd3,
      WAIT_ACK = 3'd4
   } rtl_bigreg_writer_state_t;

   // Word-counter width; a single-word register still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rtl_bigreg_writer_if.sv
// ============================================================================
// Module : rtl_bigreg_writer_if
// Brief  : Publish handshake, mem-map write beat and PS ack bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rtl_bigreg_writer_if
   import rtl_bigreg_writer_pkg::*;
#(
   parameter int DATA_WIDTH = BUFF_TIMESTAMP_WIDTH,
   parameter int WORD_WIDTH = WD_DATA_WIDTH,
   parameter int ID_WIDTH   = MEM_ID_WIDTH
) ();

   logic [DATA_WIDTH-1:0] data_in;
   logic                  data_valid_in;
   logic                  data_ready_out;
   logic                  mem_wr_en;
   logic [ID_WIDTH-1:0]   mem_wr_id;
   logic [WORD_WIDTH-1:0] mem_wr_data;
   logic                  mem_wr_ready;
   logic                  ps_ack;
   logic                  busy;
   logic                  timeout_pulse;

   // Environment side: value source, mem-map arbiter and PS ack.
   modport master (
      output data_in, data_valid_in, mem_wr_ready, ps_ack,
      input  data_ready_out, mem_wr_en, mem_wr_id, mem_wr_data, busy, timeout_pulse
   );

   modport slave (
      input  data_in, data_valid_in, mem_wr_ready, ps_ack,
      output data_ready_out, mem_wr_en, mem_wr_id, mem_wr_data, busy, timeout_pulse
   );

endinterface

`default_nettype wire

// File: rtl/rtl_bigreg_writer_mmio_wr_skid.sv
// ============================================================================
// Module : mmio_wr_skid
// Brief  : One-entry mem-map write register; holds the beat under backpressure.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mmio_wr_skid #(
   parameter int ID_WIDTH   = 8,
   parameter int WORD_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [ID_WIDTH-1:0]   load_id,
   input  logic [WORD_WIDTH-1:0] load_data,
   input  logic                  wr_ready,
   output logic                  wr_en,
   output logic [ID_WIDTH-1:0]   wr_id,
   output logic [WORD_WIDTH-1:0] wr_data,
   output logic                  beat_done
);

   logic                  r_en;
   logic [ID_WIDTH-1:0]   r_id;
   logic [WORD_WIDTH-1:0] r_data;

   // Callers only load when the register is empty or its beat completes now,
   // so a load never overwrites an unaccepted beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en   <= 1'b0;
         r_id   <= '0;
         r_data <= '0;
      end else if (load) begin
         r_en   <= 1'b1;
         r_id   <= load_id;
         r_data <= load_data;
      end else if (r_en && wr_ready) begin
         r_en   <= 1'b0;
      end
   end

   assign wr_en     = r_en;
   assign wr_id     = r_id;
   assign wr_data   = r_data;
   assign beat_done = r_en & wr_ready;

endmodule

`default_nettype wire

// File: rtl/rtl_bigreg_writer.sv
// ============================================================================
// Module : rtl_bigreg_writer
// Brief  : Publishes one wide value as invalidate / words LSW-first / set-valid
//          mem-map writes, then waits for the PS read ack.
//          Optional ack timeout: define BIGREG_ACK_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rtl_bigreg_writer
   import rtl_bigreg_writer_pkg::*;
#(
   parameter int DATA_WIDTH     = BUFF_TIMESTAMP_WIDTH,
   parameter int WORD_WIDTH     = WD_DATA_WIDTH,
   parameter int ID_WIDTH       = MEM_ID_WIDTH,
   parameter int BASE_ID        = BUFF_TIME_BASE_ID,
   parameter int VALID_ID       = BUFF_TIME_VALID_ID,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               rst,
   rtl_bigreg_writer_if.slave bus
);

   localparam int SAMPLES    = DATA_WIDTH / WORD_WIDTH;
   localparam int IDX_W      = idx_width(SAMPLES);
   localparam int WORD_SLOTS = 1 << IDX_W;

   localparam logic [ID_WIDTH-1:0] c_base_id  = ID_WIDTH'(BASE_ID);
   localparam logic [ID_WIDTH-1:0] c_valid_id = ID_WIDTH'(VALID_ID);
   localparam logic [IDX_W-1:0]    c_last_idx = IDX_W'(SAMPLES - 1);

   if (DATA_WIDTH % WORD_WIDTH != 0) begin : g_bad_ratio
      $error("DATA_WIDTH must be a multiple of WORD_WIDTH");
   end
   if (!((BASE_ID + SAMPLES - 1 < VALID_ID) || (VALID_ID < BASE_ID))) begin : g_bad_layout
      $error("word IDs overlap VALID_ID");
   end
   if ((BASE_ID + SAMPLES - 1 >= (1 << ID_WIDTH)) || (VALID_ID >= (1 << ID_WIDTH))) begin : g_bad_id_range
      $error("mem-map IDs do not fit in ID_WIDTH");
   end

   rtl_bigreg_writer_state_t r_state, w_state_nxt;
   logic [IDX_W-1:0]         r_idx, w_idx_nxt, w_idx_inc;
   logic [DATA_WIDTH-1:0]    r_shadow;
   logic [WORD_WIDTH-1:0]    w_words [WORD_SLOTS];
   logic                     w_accept;
   logic                     w_load;
   logic [ID_WIDTH-1:0]      w_load_id;
   logic [WORD_WIDTH-1:0]    w_load_data;
   logic                     w_beat_done;

   // Unused slots above SAMPLES read as zero so the word index never overruns.
   for (genvar j = 0; j < WORD_SLOTS; j++) begin : g_split
      if (j < SAMPLES) begin : g_word
         assign w_words[j] = r_shadow[j*WORD_WIDTH +: WORD_WIDTH];
      end else begin : g_pad
         assign w_words[j] = '0;
      end
   end

   assign w_accept           = bus.data_valid_in && (r_state == IDLE);
   assign w_idx_inc          = r_idx + IDX_W'(1);
   assign bus.data_ready_out = (r_state == IDLE);
   assign bus.busy           = (r_state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow <= '0;
      end else if (w_accept) begin
         r_shadow <= bus.data_in;
      end
   end

`ifdef BIGREG_ACK_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   logic [TO_W-1:0] r_to_cnt;
   logic            r_timeout;
   logic            w_timeout;

   // Count runs down while waiting; reaching 1 with no ack fires the timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_timeout;
         if ((r_state == SETV) && (w_state_nxt == WAIT_ACK)) begin
            r_to_cnt <= TO_W'(TIMEOUT_CYCLES);
         end else if ((r_state == WAIT_ACK) && (r_to_cnt != '0)) begin
            r_to_cnt <= r_to_cnt - TO_W'(1);
         end
      end
   end

   assign bus.timeout_pulse = r_timeout;
`else
   assign bus.timeout_pulse = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      w_load_id   = c_valid_id;
      w_load_data = '0;
`ifdef BIGREG_ACK_TIMEOUT_EN
      w_timeout   = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = INVAL;
               w_load      = 1'b1;
            end
         end
         INVAL: begin
            if (w_beat_done) begin
               w_state_nxt = WORDS;
               w_idx_nxt   = '0;
               w_load      = 1'b1;
               w_load_id   = c_base_id;
               w_load_data = w_words[0];
            end
         end
         WORDS: begin
            if (w_beat_done) begin
               w_load = 1'b1;
               if (r_idx == c_last_idx) begin
                  w_state_nxt = SETV;
                  w_load_data = WORD_WIDTH'(1);
               end else begin
                  w_idx_nxt   = w_idx_inc;
                  w_load_id   = c_base_id + ID_WIDTH'(w_idx_inc);
                  w_load_data = w_words[w_idx_inc];
               end
            end
         end
         SETV: begin
            if (w_beat_done) begin
               w_state_nxt = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (bus.ps_ack) begin
               w_state_nxt = IDLE;
            end
`ifdef BIGREG_ACK_TIMEOUT_EN
            else if (r_to_cnt == TO_W'(1)) begin
               w_state_nxt = IDLE;
               w_timeout   = 1'b1;
            end
`endif
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   mmio_wr_skid #(
      .ID_WIDTH   (ID_WIDTH),
      .WORD_WIDTH (WORD_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load),
      .load_id   (w_load_id),
      .load_data (w_load_data),
      .wr_ready  (bus.mem_wr_ready),
      .wr_en     (bus.mem_wr_en),
      .wr_id     (bus.mem_wr_id),
      .wr_data   (bus.mem_wr_data),
      .beat_done (w_beat_done)
   );

endmodule

`default_nettype wire

// File: tb/tb_rtl_bigreg_writer.sv
// ============================================================================
// Module : tb_rtl_bigreg_writer
// Brief  : Directed vector bench for rtl_bigreg_writer (default 32/16 layout).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rtl_bigreg_writer;
   import rtl_bigreg_writer_pkg::*;

   localparam int TO_CYC = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rtl_bigreg_writer_if #(.DATA_WIDTH(32), .WORD_WIDTH(16), .ID_WIDTH(8)) bus ();

   rtl_bigreg_writer #(
      .DATA_WIDTH     (32),
      .WORD_WIDTH     (16),
      .ID_WIDTH       (8),
      .BASE_ID        (27),
      .VALID_ID       (29),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] data;
      int          stall_beat;
      int          stall_len;
      bit          pre_ack;
      bit          ack_at_setv;
      logic [15:0] lsw;
      logic [15:0] msw;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one value and drives/checks the four write beats up to WAIT_ACK.
   task automatic publish(input logic [31:0] data, input int stall_beat, input int stall_len,
                          input bit ack_at_setv, input logic [15:0] lsw, input logic [15:0] msw);
      mem_wr_beat_t exp_b [4];
      int nb;
      int cyc;
      int stalled;
      exp_b[0] = '{id: 8'd29, data: 16'h0000};
      exp_b[1] = '{id: 8'd27, data: lsw};
      exp_b[2] = '{id: 8'd28, data: msw};
      exp_b[3] = '{id: 8'd29, data: 16'h0001};
      nb = 0;
      cyc = 0;
      stalled = 0;
      chk("ready_before_publish", 32'(bus.data_ready_out), 32'd1);
      bus.data_in       = data;
      bus.data_valid_in = 1'b1;
      tick();
      bus.data_valid_in = 1'b0;
      chk("busy_after_accept", 32'(bus.busy), 32'd1);
      chk("ready_after_accept", 32'(bus.data_ready_out), 32'd0);
      while (nb < 4 && cyc < 40) begin
         if (nb == stall_beat && stalled < stall_len) begin
            bus.mem_wr_ready = 1'b0;
            stalled++;
            chk("beat_hold", 32'({bus.mem_wr_en, bus.mem_wr_id, bus.mem_wr_data}),
                32'({1'b1, exp_b[nb]}));
         end else begin
            bus.mem_wr_ready = 1'b1;
            chk("beat", 32'({bus.mem_wr_en, bus.mem_wr_id, bus.mem_wr_data}),
                32'({1'b1, exp_b[nb]}));
            if (ack_at_setv && nb == 3) bus.ps_ack = 1'b1;
            nb++;
         end
         tick();
         bus.ps_ack = 1'b0;
         cyc++;
      end
      bus.mem_wr_ready = 1'b1;
      chk("publish_cycles", 32'(cyc), 32'(BUFF_TIME_PUBLISH_BEATS + stall_len));
      chk("wr_en_after_setv", 32'(bus.mem_wr_en), 32'd0);
      chk("busy_in_wait_ack", 32'(bus.busy), 32'd1);
   endtask

   // Confirms the block keeps waiting, then acks and checks the return to IDLE.
   task automatic ack_and_check();
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("still_waiting", 32'({bus.busy, bus.data_ready_out, bus.mem_wr_en}), 32'b100);
      end
      bus.ps_ack = 1'b1;
      tick();
      bus.ps_ack = 1'b0;
      chk("ready_after_ack", 32'(bus.data_ready_out), 32'd1);
      chk("busy_after_ack", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs [4];
      vecs[0] = '{data: 32'hDEADBEEF, stall_beat: -1, stall_len: 0, pre_ack: 1'b0,
                  ack_at_setv: 1'b0, lsw: 16'hBEEF, msw: 16'hDEAD};
      vecs[1] = '{data: 32'hDEADBEEF, stall_beat: 1, stall_len: 3, pre_ack: 1'b0,
                  ack_at_setv: 1'b0, lsw: 16'hBEEF, msw: 16'hDEAD};
      vecs[2] = '{data: 32'hA5A50F0F, stall_beat: 0, stall_len: 1, pre_ack: 1'b1,
                  ack_at_setv: 1'b0, lsw: 16'h0F0F, msw: 16'hA5A5};
      vecs[3] = '{data: 32'hFFFF0001, stall_beat: 3, stall_len: 2, pre_ack: 1'b0,
                  ack_at_setv: 1'b1, lsw: 16'h0001, msw: 16'hFFFF};

      bus.data_in       = '0;
      bus.data_valid_in = 1'b0;
      bus.mem_wr_ready  = 1'b1;
      bus.ps_ack        = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_ready", 32'(bus.data_ready_out), 32'd1);
      chk("rst_outputs", 32'({bus.mem_wr_en, bus.mem_wr_id, bus.mem_wr_data, bus.busy, bus.timeout_pulse}),
          32'd0);
      rst = 1'b0;
      tick();

      for (int v = 0; v < 4; v++) begin
         if (vecs[v].pre_ack) begin
            bus.ps_ack = 1'b1;
            tick();
            bus.ps_ack = 1'b0;
            chk("idle_ack_ignored", 32'({bus.busy, bus.data_ready_out}), 32'b01);
         end
         publish(vecs[v].data, vecs[v].stall_beat, vecs[v].stall_len, vecs[v].ack_at_setv,
                 vecs[v].lsw, vecs[v].msw);
         ack_and_check();
      end

      // A value offered during WAIT_ACK stays pending until the ack.
      publish(32'hDEADBEEF, -1, 0, 1'b0, 16'hBEEF, 16'hDEAD);
      bus.data_in       = 32'h12345678;
      bus.data_valid_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("busy_blocks_accept", 32'({bus.data_ready_out, bus.mem_wr_en, bus.busy}), 32'b001);
      end
      bus.ps_ack = 1'b1;
      tick();
      bus.ps_ack = 1'b0;
      chk("pending_ready", 32'(bus.data_ready_out), 32'd1);
      publish(32'h12345678, -1, 0, 1'b0, 16'h5678, 16'h1234);

`ifdef BIGREG_ACK_TIMEOUT_EN
      for (int k = 1; k <= TO_CYC; k++) begin
         tick();
         if (k == TO_CYC - 1) chk("timeout_early", 32'({bus.timeout_pulse, bus.busy}), 32'b01);
         if (k == TO_CYC) chk("timeout_fire", 32'({bus.timeout_pulse, bus.busy, bus.data_ready_out}), 32'b101);
      end
      tick();
      chk("timeout_one_cycle", 32'(bus.timeout_pulse), 32'd0);
`else
      for (int k = 0; k < 3 * TO_CYC; k++) tick();
      chk("wait_forever", 32'({bus.busy, bus.timeout_pulse}), 32'b10);
      ack_and_check();
`endif

      // Asynchronous reset while the MSW beat is being presented.
      bus.data_in       = 32'hCAFEF00D;
      bus.data_valid_in = 1'b1;
      tick();
      bus.data_valid_in = 1'b0;
      tick();
      tick();
      chk("pre_reset_beat", 32'({bus.mem_wr_en, bus.mem_wr_id, bus.mem_wr_data}), 32'({1'b1, 8'd28, 16'hCAFE}));
      rst = 1'b1;
      #1;
      chk("async_reset", 32'({bus.mem_wr_en, bus.busy, bus.data_ready_out}), 32'b001);
      tick();
      rst = 1'b0;
      tick();
      publish(32'h13579BDF, -1, 0, 1'b0, 16'h9BDF, 16'h1357);
      ack_and_check();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rtl_bigreg_writer.md
Name: rtl_bigreg_writer

Overview:
RTL-side publisher for RTL_BIGREG registers in the MMIO map, such as the 32-bit buffer timestamp at IDs 27..28 with its valid flag at ID 29. It accepts one wide value over a valid/ready handshake and splits it into WD_DATA_WIDTH words. It writes those words into consecutive mem-map entries, then raises the valid entry and holds off until the PS acknowledges the read. It sits between the buffer/timestamp logic and the mem-map write arbiter.

Parameters:
DATA_WIDTH, 32 (`BUFF_TIMESTAMP_WIDTH), width of the value to publish
WORD_WIDTH, 16 (`WD_DATA_WIDTH), width of one mem-map entry
ID_WIDTH, 8 ($clog2(`MEM_SIZE)), width of a mem-map index
BASE_ID, 27 (`BUFF_TIME_BASE_ID), index of the least-significant word
VALID_ID, 29 (`BUFF_TIME_VALID_ID), index of the valid flag
TIMEOUT_CYCLES, 1024, WAIT_ACK timeout length; used only with the optional feature

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
data_in  in  DATA_WIDTH  value to publish
data_valid_in  in  1  data_in is valid
data_ready_out  out  1  block can accept a value
mem_wr_en  out  1  write request to the mem map
mem_wr_id  out  ID_WIDTH  mem-map index for the write
mem_wr_data  out  WORD_WIDTH  write data
mem_wr_ready  in  1  mem map accepts the current write this cycle
ps_ack  in  1  one-cycle pulse: PS has read VALID_ID
busy  out  1  state != IDLE
timeout_pulse  out  1  ack timeout fired (feature only; tied 0 otherwise)

Behaviour:
- Reset: asynchronous, active-high. State=IDLE and word counter=0. All outputs 0 except data_ready_out=1.
- SAMPLES = DATA_WIDTH/WORD_WIDTH. A non-integer ratio is an elaboration error. Require BASE_ID+SAMPLES-1 < VALID_ID or VALID_ID < BASE_ID.
- data_ready_out = (state==IDLE). A transfer happens when data_valid_in & data_ready_out; data_in is then registered into a shadow reg.
- Every write beat follows valid/ready rules:
  - mem_wr_en/id/data are registered and stay stable while mem_wr_ready=0.
  - A beat completes on the cycle with mem_wr_en & mem_wr_ready.
- FSM:
  - IDLE: on transfer -> INVAL. Drive (VALID_ID, 0) the next cycle.
  - INVAL: on beat complete -> WORDS, i=0.
  - WORDS: drive (BASE_ID+i, shadow[i*WORD_WIDTH +: WORD_WIDTH]), LSW first. On each beat complete i++. After beat i=SAMPLES-1 -> SETV.
  - SETV: drive (VALID_ID, 1). On beat complete -> WAIT_ACK, mem_wr_en=0.
  - WAIT_ACK: on ps_ack -> IDLE.
- With mem_wr_ready held 1, accept-to-SETV-complete is SAMPLES+2 cycles and mem_wr_en stays high continuously across beats. The next beat is presented in the cycle right after the previous one completes.
- ps_ack outside WAIT_ACK is ignored and not remembered. ps_ack in the same cycle as the SETV beat completing is also ignored.
- data_valid_in while busy: not accepted; the source holds the value.
- Reset mid-sequence: immediate return to IDLE, mem_wr_en drops asynchronously. Partially written entries stay in the map; VALID_ID stays 0 if INVAL had completed. No recovery write is issued.
- Word IDs are computed in ID_WIDTH arithmetic; parameter checks guarantee no wrap.

Optional Feature:
BIGREG_ACK_TIMEOUT_EN.
- Defined: a counter loads on entering WAIT_ACK. If TIMEOUT_CYCLES cycles pass with no ps_ack, the block pulses timeout_pulse for 1 cycle and goes to IDLE. VALID_ID remains 1 (stale value stays readable); the next publish invalidates it first.
- Undefined: no counter, WAIT_ACK waits forever, and timeout_pulse is tied 0.

Decomposition:
- mem_layout_pkg: add a typedef for the mem-map write beat {id, data}, an enum for rtl_bigreg_writer_state_t {IDLE, INVAL, WORDS, SETV, WAIT_ACK}, and a constant BUFF_TIME_PUBLISH_BEATS = `BUFF_SAMPLES+2.
- One natural sub-module, mmio_wr_skid: a one-entry output register holding the beat stable under mem_wr_ready backpressure. Reusable by other RTL_BIGREG publishers.

Test Plan:
1. Reset, data_in=0xDEADBEEF pulsed, mem_wr_ready=1 -> beats (29,0x0000), (27,0xBEEF), (28,0xDEAD), (29,0x0001) on 4 consecutive cycles. data_ready_out stays 0 until ps_ack, then returns to 1 the cycle after.
2. Same stimulus with mem_wr_ready low for 3 cycles during beat (27,0xBEEF) -> id/data held stable; no beat skipped or duplicated.
3. Second value 0x12345678 offered in WAIT_ACK -> not accepted. After ps_ack it publishes (29,0), (27,0x5678), (28,0x1234), (29,1).
4. ps_ack pulsed in IDLE, then a publish -> block still waits in WAIT_ACK for a fresh ps_ack.
5. rst asserted after beat (27,..) -> mem_wr_en=0 immediately, busy=0, data_ready_out=1. A new publish restarts with (29,0).
6. BIGREG_ACK_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no ps_ack -> timeout_pulse high exactly 16 cycles after entering WAIT_ACK; block returns to IDLE.
